// File: rtl/ysyx_23060072_ifetch_ctrl.sv
// ysyx_23060072_ifetch_ctrl
//   Instruction-fetch controller. It keeps at most one request outstanding,
//   holds each returned instruction until decode takes it, and redirects the
//   fetch PC on a branch/jump. An in-flight response that a redirect has made
//   stale is dropped.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   redirect_valid_i/pc_i     redirect request and target
//   imem_req_valid_o/ready_i  fetch request handshake, imem_addr_o = byte address
//   imem_rsp_valid_i/data_i   returned instruction word
//   id_valid_o/ready_i        instruction handshake to decode, id_pc_o/id_inst_o payload
//   misalign_o                sticky misaligned-redirect flag (only with the macro)
//
// Optional feature macro: YSYX_23060072_IFU_MISALIGN_EN
//   Defined: a redirect target with nonzero low bits halts fetch until reset.
//   Undefined: the two low target bits are forced to zero.

module ysyx_23060072_ifetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o
`ifdef YSYX_23060072_IFU_MISALIGN_EN
   ,
   output logic        misalign_o
`endif
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
`ifdef YSYX_23060072_IFU_MISALIGN_EN
      ,
      S_HALT = 2'd3
`endif
   } state_t;

   state_t            r_state, w_state_n;
   logic [XLEN-1:0]   r_pc, w_pc_n;
   logic [XLEN-1:0]   r_pend, w_pend_n;
   logic              r_discard, w_discard_n;
   logic              r_req_valid, w_req_valid_n;
   logic              r_id_valid, w_id_valid_n;
   logic [XLEN-1:0]   r_id_pc, w_id_pc_n;
   logic [XLEN-1:0]   r_id_inst, w_id_inst_n;
   logic [XLEN-1:0]   w_redir_pc;
   logic              w_hs;

`ifdef YSYX_23060072_IFU_MISALIGN_EN
   logic              r_misalign, w_misalign_n;
   logic              w_redir_bad;
   assign w_redir_pc  = redirect_pc_i;
   assign w_redir_bad = redirect_valid_i & (|redirect_pc_i[1:0]);
`else
   // Low target bits are dropped; this keeps them visibly consumed.
   logic              w_unused;
   assign w_unused    = ^redirect_pc_i[1:0];
   assign w_redir_pc  = {redirect_pc_i[XLEN-1:2], 2'b00};
`endif

   assign w_hs = (r_state == S_REQ) & r_req_valid & imem_req_ready_i;

   // Next-state and registered-output computation
   always_comb begin
      w_state_n    = r_state;
      w_pc_n       = r_pc;
      w_pend_n     = r_pend;
      w_discard_n  = r_discard;
      w_id_valid_n = r_id_valid;
      w_id_pc_n    = r_id_pc;
      w_id_inst_n  = r_id_inst;
`ifdef YSYX_23060072_IFU_MISALIGN_EN
      w_misalign_n = r_misalign;
`endif
      case (r_state)
         S_REQ: begin
            if (redirect_valid_i) begin
               w_pc_n = w_redir_pc;
               // Request already accepted for the old path: its response is stale
               if (w_hs) begin
                  w_state_n   = S_WAIT;
                  w_discard_n = 1'b1;
               end
            end else if (w_hs) begin
               w_state_n   = S_WAIT;
               w_pend_n    = r_pc;
               w_discard_n = 1'b0;
            end
         end
         S_WAIT: begin
            if (redirect_valid_i) begin
               w_pc_n = w_redir_pc;
               // A same-cycle response is the stale one; otherwise drop it later
               if (imem_rsp_valid_i) begin
                  w_state_n   = S_REQ;
                  w_discard_n = 1'b0;
               end else begin
                  w_discard_n = 1'b1;
               end
            end else if (imem_rsp_valid_i) begin
               if (r_discard) begin
                  w_state_n   = S_REQ;
                  w_discard_n = 1'b0;
               end else begin
                  w_state_n    = S_HOLD;
                  w_id_valid_n = 1'b1;
                  w_id_pc_n    = r_pend;
                  w_id_inst_n  = imem_rsp_data_i;
                  w_pc_n       = r_pend + XLEN'(4);
               end
            end
         end
         S_HOLD: begin
            if (redirect_valid_i) begin
               w_pc_n       = w_redir_pc;
               w_id_valid_n = 1'b0;
               w_state_n    = S_REQ;
            end else if (id_ready_i) begin
               w_id_valid_n = 1'b0;
               w_state_n    = S_REQ;
            end
         end
`ifdef YSYX_23060072_IFU_MISALIGN_EN
         S_HALT: w_state_n = S_HALT;
`endif
         default: w_state_n = S_REQ;
      endcase
`ifdef YSYX_23060072_IFU_MISALIGN_EN
      // Misaligned redirect overrides everything and parks the fetch unit
      if ((r_state != S_HALT) && w_redir_bad) begin
         w_state_n    = S_HALT;
         w_misalign_n = 1'b1;
         w_id_valid_n = 1'b0;
         w_discard_n  = 1'b0;
      end
`endif
      // Request valid is registered so it stays low through reset
      w_req_valid_n = (w_state_n == S_REQ);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_pend      <= '0;
         r_discard   <= 1'b0;
         r_req_valid <= 1'b0;
         r_id_valid  <= 1'b0;
         r_id_pc     <= '0;
         r_id_inst   <= '0;
`ifdef YSYX_23060072_IFU_MISALIGN_EN
         r_misalign  <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_n;
         r_pc        <= w_pc_n;
         r_pend      <= w_pend_n;
         r_discard   <= w_discard_n;
         r_req_valid <= w_req_valid_n;
         r_id_valid  <= w_id_valid_n;
         r_id_pc     <= w_id_pc_n;
         r_id_inst   <= w_id_inst_n;
`ifdef YSYX_23060072_IFU_MISALIGN_EN
         r_misalign  <= w_misalign_n;
`endif
      end
   end

   assign imem_req_valid_o = r_req_valid;
   assign imem_addr_o      = r_pc;
   assign id_valid_o       = r_id_valid;
   assign id_pc_o          = r_id_pc;
   assign id_inst_o        = r_id_inst;
`ifdef YSYX_23060072_IFU_MISALIGN_EN
   assign misalign_o       = r_misalign;
`endif

endmodule

// File: tb/tb_ysyx_23060072_ifetch_ctrl.sv
// Testbench for ysyx_23060072_ifetch_ctrl: two instances (default RESET_PC and
// RESET_PC = FFFF_FFFC) share one stimulus stream. A transaction-level model
// predicts each cycle's outputs; a monitor pops and compares them.
// Optional feature macro: YSYX_23060072_IFU_MISALIGN_EN

module tb_ysyx_23060072_ifetch_ctrl;

`ifdef YSYX_23060072_IFU_MISALIGN_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_ready_i;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        id_ready_i;

   logic        req_valid_a, req_valid_b;
   logic [31:0] addr_a, addr_b;
   logic        id_valid_a, id_valid_b;
   logic [31:0] id_pc_a, id_pc_b;
   logic [31:0] id_inst_a, id_inst_b;
   logic        mis_a, mis_b;

   ysyx_23060072_ifetch_ctrl u_dut (
      .clk              (clk),
      .rst              (rst),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_valid_o (req_valid_a),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_addr_o      (addr_a),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .id_valid_o       (id_valid_a),
      .id_ready_i       (id_ready_i),
      .id_pc_o          (id_pc_a),
      .id_inst_o        (id_inst_a)
`ifdef YSYX_23060072_IFU_MISALIGN_EN
      ,
      .misalign_o       (mis_a)
`endif
   );

   ysyx_23060072_ifetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk              (clk),
      .rst              (rst),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_valid_o (req_valid_b),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_addr_o      (addr_b),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .id_valid_o       (id_valid_b),
      .id_ready_i       (id_ready_i),
      .id_pc_o          (id_pc_b),
      .id_inst_o        (id_inst_b)
`ifdef YSYX_23060072_IFU_MISALIGN_EN
      ,
      .misalign_o       (mis_b)
`endif
   );

`ifndef YSYX_23060072_IFU_MISALIGN_EN
   assign mis_a = 1'b0;
   assign mis_b = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        chk;
      logic        rst_last;
      logic        req_v;
      logic        id_v;
      logic        mis;
      logic [31:0] addr;
      logic [31:0] addr2;
      logic [31:0] id_pc;
      logic [31:0] id_pc2;
      logic [31:0] id_inst;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: transaction view of the fetch unit
   logic        m_chk = 1'b0;
   logic        m_rst_last = 1'b0;
   logic        m_out = 1'b0;     // request accepted, response not yet seen
   logic        m_kill = 1'b0;    // outstanding response belongs to an old path
   logic        m_held = 1'b0;    // instruction offered to decode
   logic        m_halt = 1'b0;
   logic        m_mis = 1'b0;
   logic [31:0] m_pc = '0, m_pc2 = '0;
   logic [31:0] m_addr = '0, m_addr2 = '0;
   logic [31:0] m_idpc = '0, m_idpc2 = '0, m_idinst = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // One clock of stimulus: record this cycle's expected outputs, drive the
   // inputs for the coming edge, and advance the model across that edge.
   task automatic step(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic rspv, input logic idr);
      exp_t        e;
      logic        req_now;
      logic        hs;
      logic [31:0] tgt;
      @(negedge clk);
      req_now    = !m_rst_last && !m_out && !m_held && !m_halt;
      e.chk      = m_chk;
      e.rst_last = m_rst_last;
      e.req_v    = req_now;
      e.id_v     = m_held;
      e.mis      = m_mis;
      e.addr     = m_pc;
      e.addr2    = m_pc2;
      e.id_pc    = m_idpc;
      e.id_pc2   = m_idpc2;
      e.id_inst  = m_idinst;
      exp_q.push_back(e);

      rst              = r;
      redirect_valid_i = rv;
      redirect_pc_i    = rpc;
      imem_req_ready_i = rdy;
      imem_rsp_valid_i = rspv;
      imem_rsp_data_i  = (rspv && m_out) ? mem_word(m_addr) : $urandom();
      id_ready_i       = idr;

      hs  = req_now && rdy;
      tgt = rpc & 32'hFFFF_FFFC;
      if (r) begin
         m_chk = 1'b1; m_out = 1'b0; m_kill = 1'b0; m_held = 1'b0;
         m_halt = 1'b0; m_mis = 1'b0;
         m_pc = 32'h8000_0000; m_pc2 = 32'hFFFF_FFFC;
         m_idpc = '0; m_idpc2 = '0; m_idinst = '0;
      end else if (m_halt) begin
         m_halt = 1'b1;
      end else if (rv && MIS_EN && (rpc[1:0] != 2'b00)) begin
         m_halt = 1'b1; m_mis = 1'b1; m_held = 1'b0; m_out = 1'b0;
      end else if (rv) begin
         m_pc = tgt; m_pc2 = tgt; m_held = 1'b0;
         if (hs) begin
            m_out = 1'b1; m_kill = 1'b1;
         end else if (m_out) begin
            if (rspv) begin m_out = 1'b0; m_kill = 1'b0; end
            else m_kill = 1'b1;
         end
      end else if (hs) begin
         m_out = 1'b1; m_kill = 1'b0; m_addr = m_pc; m_addr2 = m_pc2;
      end else if (m_out && rspv) begin
         m_out = 1'b0;
         if (m_kill) m_kill = 1'b0;
         else begin
            m_held = 1'b1; m_idpc = m_addr; m_idpc2 = m_addr2;
            m_idinst = imem_rsp_data_i;
            m_pc = m_addr + 32'd4; m_pc2 = m_addr2 + 32'd4;
         end
      end else if (m_held && idr) begin
         m_held = 1'b0;
      end
      m_rst_last = r;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   // Monitor: compare each cycle's outputs with the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               chk("req_valid",      32'(req_valid_a), 32'(e.req_v));
               chk("req_valid_wrap", 32'(req_valid_b), 32'(e.req_v));
               if (e.req_v) begin
                  chk("req_addr",      addr_a, e.addr);
                  chk("req_addr_wrap", addr_b, e.addr2);
               end
               chk("id_valid",      32'(id_valid_a), 32'(e.id_v));
               chk("id_valid_wrap", 32'(id_valid_b), 32'(e.id_v));
               if (e.id_v || e.rst_last) begin
                  chk("id_pc",        id_pc_a,   e.id_pc);
                  chk("id_inst",      id_inst_a, e.id_inst);
                  chk("id_pc_wrap",   id_pc_b,   e.id_pc2);
                  chk("id_inst_wrap", id_inst_b, e.id_inst);
               end
               if (MIS_EN) begin
                  chk("misalign",      32'(mis_a), 32'(e.mis));
                  chk("misalign_wrap", 32'(mis_b), 32'(e.mis));
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      int          n;
      logic [31:0] rpc;
      rst = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;
      imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
      id_ready_i = 1'b0;

      // Reset, then streaming fetch with an always-ready single-cycle memory
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      repeat (12) step(1'b0, 1'b0, '0, 1'b1, m_out, 1'b1);

      // Decode stalls for several cycles on a held instruction
      n = 0;
      while (!m_held && n < 20) begin step(1'b0, 1'b0, '0, 1'b1, m_out, 1'b0); n++; end
      if (!m_held) begin n_errors++; $display("FAIL reach_hold timeout"); end
      repeat (5) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);

      // Redirect while waiting, with the stale response in the same cycle
      n = 0;
      while (!m_out && n < 20) begin step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1); n++; end
      if (!m_out) begin n_errors++; $display("FAIL reach_wait timeout"); end
      step(1'b0, 1'b1, 32'h8000_0100, 1'b1, 1'b1, 1'b1);
      repeat (8) step(1'b0, 1'b0, '0, 1'b1, m_out, 1'b1);

      // Redirect while holding, with decode ready in the same cycle
      n = 0;
      while (!m_held && n < 20) begin step(1'b0, 1'b0, '0, 1'b1, m_out, 1'b0); n++; end
      if (!m_held) begin n_errors++; $display("FAIL reach_hold2 timeout"); end
      step(1'b0, 1'b1, 32'h8000_0040, 1'b1, 1'b0, 1'b1);
      repeat (10) step(1'b0, 1'b0, '0, 1'b1, m_out, 1'b1);

      // Redirect just below the top of the address space to wrap the PC
      step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1);
      repeat (15) step(1'b0, 1'b0, '0, 1'b1, m_out, 1'b1);

      // Randomized traffic: stalls, spurious responses, redirects, resets
      repeat (800) begin
         rpc = ($urandom() % 4 == 0) ? 32'hFFFF_FFF8 : $urandom();
         if (MIS_EN) rpc = rpc & 32'hFFFF_FFFC;
         step(($urandom() % 100) == 0,
              ($urandom() % 16) == 0,
              rpc,
              ($urandom() % 10) < 7,
              m_out ? (($urandom() % 2) == 0) : (($urandom() % 20) == 0),
              ($urandom() % 10) < 6);
      end

      // Redirect with nonzero low bits, then reset and restart
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0, '0, 1'b1, m_out, 1'b1);
      step(1'b0, 1'b1, 32'h8000_0002, 1'b1, m_out, 1'b1);
      repeat (8) step(1'b0, 1'b0, '0, 1'b1, ($urandom() % 2) == 0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      repeat (8) step(1'b0, 1'b0, '0, 1'b1, m_out, 1'b1);

      repeat (2) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ysyx_23060072_ifetch_ctrl.md
YSYX_23060072_IFETCH_CTRL -- requirements
Module: ysyx_23060072_ifetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-004 SHALL have port redirect_valid_i input 1: branch/jump redirect request.
REQ-005 SHALL have port redirect_pc_i input 32: redirect target.
REQ-006 SHALL have port imem_req_valid_o output 1: fetch request valid.
REQ-007 SHALL have port imem_req_ready_i input 1: instruction memory accepts request.
REQ-008 SHALL have port imem_addr_o output 32: fetch byte address.
REQ-009 SHALL have port imem_rsp_valid_i input 1: instruction data returned.
REQ-010 SHALL have port imem_rsp_data_i input 32: returned instruction word.
REQ-011 SHALL have port id_valid_o output 1: instruction valid to decode.
REQ-012 SHALL have port id_ready_i input 1: decode accepts instruction.
REQ-013 SHALL have port id_pc_o output 32: PC of delivered instruction.
REQ-014 SHALL have port id_inst_o output 32: delivered instruction word.
REQ-015 SHALL have port misalign_o output 1, present only with YSYX_23060072_IFU_MISALIGN_EN: sticky misaligned-redirect flag.

Function
REQ-016 SHALL implement FSM states REQ, WAIT, HOLD, plus HALT only with the macro; all outputs SHALL be registered or decoded from state only.
REQ-017 In REQ, SHALL drive imem_req_valid_o=1 and imem_addr_o=pc; a handshake with valid=1 and ready=1 SHALL move to WAIT and latch pc as pending PC.
REQ-018 In WAIT, imem_req_valid_o SHALL be 0, giving at most one outstanding request; imem_rsp_valid_i=1 SHALL latch id_inst_o=data and id_pc_o=pending PC, set pc=pending+4, and move to HOLD.
REQ-019 In HOLD, id_valid_o SHALL be 1, with id_pc_o and id_inst_o stable until id_ready_i=1; acceptance SHALL move to REQ with id_valid_o=0 on the next cycle.
REQ-020 Minimum latency SHALL be: request accepted at cycle N, response at N+1, id_valid_o at N+2; peak throughput SHALL be one instruction per 3 cycles.
REQ-021 PC increment SHALL be modulo 2^32; 32'hFFFF_FFFC+4 SHALL give 32'h0000_0000.
REQ-022 redirect_valid_i SHALL have priority over all other events in every state and SHALL set pc=redirect_pc_i.
REQ-023 A redirect in REQ without a handshake SHALL stay in REQ, presenting the new pc next cycle.
REQ-024 A redirect in REQ coinciding with a handshake SHALL move to WAIT with the discard flag set.
REQ-025 A redirect in WAIT SHALL set discard, and a response arriving in the same cycle as the redirect SHALL be discarded.
REQ-026 While discard is set, a response SHALL be dropped, discard cleared, and the FSM SHALL return to REQ; a repeat redirect while discard is set SHALL only update pc.
REQ-027 A redirect in HOLD SHALL drop the held instruction, clear id_valid_o next cycle even if id_ready_i=1 in that cycle, and go to REQ.
REQ-028 imem_rsp_valid_i outside WAIT SHALL be ignored.
REQ-029 Without the macro, redirect_pc_i[1:0] SHALL be forced to 2'b00.

Reset
REQ-030 With rst=1 at an edge, the block SHALL load state=REQ, pc=RESET_PC, discard=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, and misalign_o=0.
REQ-031 While rst=1, imem_req_valid_o SHALL be 0, and it SHALL become 1 in the first cycle after rst falls.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request, and no stale response SHALL be delivered.

Configuration
REQ-033 With YSYX_23060072_IFU_MISALIGN_EN defined, a redirect whose redirect_pc_i[1:0]!=0 SHALL set misalign_o=1, go to HALT, drive imem_req_valid_o=0 and id_valid_o=0, and remain in HALT until reset.
REQ-034 Without YSYX_23060072_IFU_MISALIGN_EN, there SHALL be no misalign_o port, no HALT state, and low bits SHALL be masked per REQ-029.

Verification
REQ-035 Bench SHALL cover: release reset, memory always ready, 1-cycle response -> addresses 8000_0000, 8000_0004, 8000_0008 delivered with matching id_pc_o, one per 3 cycles.
REQ-036 Bench SHALL cover: id_ready_i=0 for 5 cycles in HOLD -> id_valid_o, id_pc_o and id_inst_o stable, no new request issued.
REQ-037 Bench SHALL cover: redirect to 8000_0100 while WAIT, with response in the same cycle -> response dropped, next request address 8000_0100.
REQ-038 Bench SHALL cover: redirect to 8000_0040 in HOLD with id_ready_i=1 -> held instruction not counted as accepted, next id_pc_o=8000_0040.
REQ-039 Bench SHALL cover: RESET_PC=FFFF_FFFC -> second request address 0000_0000.
REQ-040 Bench SHALL cover, with the macro: redirect to 8000_0002 -> misalign_o=1, no further requests; after reset, misalign_o=0 and fetch restarts at RESET_PC.
